// File: rtl/uart_pkg.sv
// Shared state encodings, rate helper and legal-range limits for uart_core.
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    localparam int MIN_CLKS_PER_BIT = 4;
    localparam int MIN_DATA_BITS    = 5;
    localparam int MAX_DATA_BITS    = 9;
    localparam int MIN_STOP_BITS    = 1;
    localparam int MAX_STOP_BITS    = 2;

    function automatic int calc_clks_per_bit(input int clock_hz, input int baud_hz);
        return clock_hz / baud_hz;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter with mid-bit and end-of-bit strobes.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic mid_strobe,
    output logic end_strobe
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    // Two cycles early: the receiver's synchroniser and IDLE->START step
    // already delay its view of the line by that much.
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 2);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q + CW'(1);
        if (clear || (count_q == LAST)) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign mid_strobe = (count_q == MID);
    assign end_strobe = (count_q == LAST);

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: valid/ready framed transmitter and mid-bit sampling
// receiver with framing-error detection, sharing only clock and reset.
module uart_core
    import uart_pkg::*;
#(
    parameter int CLOCK_HZ  = 1_000_000,
    parameter int BAUD_HZ   = 9_600,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serial_tx,
    input  logic                 serial_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err
);
    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_HZ, BAUD_HZ);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_rate
        $fatal(1, "uart_core: CLKS_PER_BIT below minimum");
    end
    if (STOP_BITS < MIN_STOP_BITS || STOP_BITS > MAX_STOP_BITS) begin : g_bad_stop
        $fatal(1, "uart_core: STOP_BITS must be 1 or 2");
    end
    if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data
        $fatal(1, "uart_core: DATA_BITS must be 5..9");
    end

    tx_state_t            tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [IW-1:0]        tx_idx_q, tx_idx_d;
    logic                 serial_tx_q, serial_tx_d;
    logic                 tx_mid_unused, tx_bit_end, tx_accept;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clock      (clock),
        .reset      (reset),
        .clear      (tx_state_q == TX_IDLE),
        .mid_strobe (tx_mid_unused),
        .end_strobe (tx_bit_end)
    );

    // Ready in the last stop-bit cycle lets the next start bit follow with no gap.
    assign tx_ready  = !reset && ((tx_state_q == TX_IDLE) ||
                       ((tx_state_q == TX_STOP) && tx_bit_end && (tx_idx_q == LAST_STOP)));
    assign tx_accept = tx_valid && tx_ready;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_idx_d   = tx_idx_q;
        unique case (tx_state_q)
            TX_IDLE: ;
            TX_START: if (tx_bit_end) begin
                tx_state_d = TX_DATA;
                tx_idx_d   = '0;
            end
            TX_DATA: if (tx_bit_end) begin
                tx_shift_d = tx_shift_q >> 1;
                if (tx_idx_q == LAST_DATA) begin
                    tx_state_d = TX_STOP;
                    tx_idx_d   = '0;
                end else begin
                    tx_idx_d = tx_idx_q + IW'(1);
                end
            end
            TX_STOP: if (tx_bit_end) begin
                if (tx_idx_q == LAST_STOP) tx_state_d = TX_IDLE;
                else                       tx_idx_d   = tx_idx_q + IW'(1);
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_accept) begin
            tx_state_d = TX_START;
            tx_shift_d = tx_data;
        end
        case (tx_state_d)
            TX_START: serial_tx_d = 1'b0;
            TX_DATA:  serial_tx_d = tx_shift_d[0];
            default:  serial_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q  <= TX_IDLE;
            tx_idx_q    <= '0;
            serial_tx_q <= 1'b1;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_idx_q    <= tx_idx_d;
            serial_tx_q <= serial_tx_d;
        end
        tx_shift_q <= tx_shift_d;
    end

    assign serial_tx = serial_tx_q;

    rx_state_t            rx_state_q, rx_state_d;
    logic                 rx_meta_q, rx_sync_q;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic [IW-1:0]        rx_idx_q, rx_idx_d;
    logic                 rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;
    logic                 rx_mid, rx_bit_end;

    // Restarting at the start-bit midpoint makes every end strobe a data midpoint.
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clock      (clock),
        .reset      (reset),
        .clear      ((rx_state_q == RX_IDLE) || ((rx_state_q == RX_START) && rx_mid)),
        .mid_strobe (rx_mid),
        .end_strobe (rx_bit_end)
    );

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_idx_d   = rx_idx_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: if (!rx_sync_q) rx_state_d = RX_START;
            RX_START: if (rx_mid) begin
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_DATA;
                    rx_idx_d   = '0;
                end
            end
            RX_DATA: if (rx_bit_end) begin
                rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                if (rx_idx_q == LAST_DATA) rx_state_d = RX_STOP;
                else                       rx_idx_d   = rx_idx_q + IW'(1);
            end
            RX_STOP: if (rx_bit_end) begin
                if (rx_sync_q) begin
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_err_d   = 1'b1;
                    rx_state_d = RX_BREAK;
                end
            end
            RX_BREAK: if (rx_sync_q) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_idx_q   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_meta_q  <= serial_rx;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_idx_q   <= rx_idx_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
        end
        rx_shift_q <= rx_shift_d;
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_err_q;

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: frame-level reference model of the
// serial line and receiver, driven with fixed and random bytes.
module tb_uart_core;
    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, serial_tx, serial_rx_w;
    logic       rx_line = 1'b1;
    logic       loop_en = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err;

    logic [6:0] tx_data7 = 7'h00;
    logic       tx_valid7 = 1'b0;
    logic       tx_ready7, serial_tx7;
    logic [6:0] rx_data7;
    logic       rx_valid7, rx_frame_err7;

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    int         rxv_cnt = 0, err_cnt = 0, rxv_cyc = 0;
    logic [7:0] rxv_data = 8'h00;
    int         rxv7_cnt = 0, err7_cnt = 0, rxv7_cyc = 0;
    logic [6:0] rxv7_data = 7'h00;

    always #5 clk = ~clk;

    assign serial_rx_w = loop_en ? serial_tx : rx_line;

    uart_core #(.CLOCK_HZ(1_000_000), .BAUD_HZ(100_000), .DATA_BITS(8), .STOP_BITS(1)) dut (
        .clock(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .serial_tx(serial_tx), .serial_rx(serial_rx_w),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err)
    );

    uart_core #(.CLOCK_HZ(1_000_000), .BAUD_HZ(100_000), .DATA_BITS(7), .STOP_BITS(2)) dut7 (
        .clock(clk), .reset(reset), .tx_data(tx_data7), .tx_valid(tx_valid7),
        .tx_ready(tx_ready7), .serial_tx(serial_tx7), .serial_rx(serial_tx7),
        .rx_data(rx_data7), .rx_valid(rx_valid7), .rx_frame_err(rx_frame_err7)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt  <= rxv_cnt + 1;
            rxv_cyc  <= cyc;
            rxv_data <= rx_data;
        end
        if (rx_frame_err) err_cnt <= err_cnt + 1;
        if (rx_valid7) begin
            rxv7_cnt  <= rxv7_cnt + 1;
            rxv7_cyc  <= cyc;
            rxv7_data <= rx_data7;
        end
        if (rx_frame_err7) err7_cnt <= err7_cnt + 1;
    end

    // Line level n cycles into a frame (n=1 is the first start-bit cycle).
    function automatic logic model_bit(input logic [8:0] data, input int dbits, input int n);
        int idx;
        idx = (n - 1) / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= dbits) return data[idx-1];
        return 1'b1;
    endfunction

    // Called at a negedge; returns at the negedge of frame cycle 1.
    task automatic tx_accept(input logic [7:0] b);
        int w;
        w = 0;
        while (!tx_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL tx_ready_wait actual=%b required=1", tx_ready);
        end
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic drive_rx_frame(input logic [7:0] b, input logic stop_lvl);
        for (int i = 0; i < 10; i++) begin
            rx_line = (i == 0) ? 1'b0 : (i <= 8) ? b[i-1] : stop_lvl;
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks += 5;
        if (serial_tx !== 1'b1) begin errors++; $display("FAIL reset_serial_tx actual=%b required=1", serial_tx); end
        if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready actual=%b required=0", tx_ready); end
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid actual=%b required=0", rx_valid); end
        if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_rx_frame_err actual=%b required=0", rx_frame_err); end
        if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data actual=%h required=00", rx_data); end
        reset = 1'b0;
        @(negedge clk);
        checks += 2;
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL post_reset_tx_ready actual=%b required=1", tx_ready); end
        if (serial_tx !== 1'b1) begin errors++; $display("FAIL post_reset_serial_tx actual=%b required=1", serial_tx); end
    endtask

    task automatic test_single_tx(input logic [7:0] b);
        logic exp;
        tx_accept(b);
        for (int n = 1; n <= 100; n++) begin
            if (n > 1) @(negedge clk);
            exp = model_bit({1'b0, b}, 8, n);
            checks += 2;
            if (serial_tx !== exp) begin
                errors++;
                $display("FAIL single_tx_bit byte=%h cycle=%0d actual=%b required=%b", b, n, serial_tx, exp);
            end
            if (tx_ready !== (n == 100)) begin
                errors++;
                $display("FAIL single_tx_ready byte=%h cycle=%0d actual=%b required=%b", b, n, tx_ready, (n == 100));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1);
        logic exp;
        int   w;
        w = 0;
        while (!tx_ready && w < 400) begin @(negedge clk); w++; end
        tx_data  = b0;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int n = 1; n <= 200; n++) begin
            if (n > 1) @(negedge clk);
            exp = (n <= 100) ? model_bit({1'b0, b0}, 8, n) : model_bit({1'b0, b1}, 8, n - 100);
            checks += 2;
            if (serial_tx !== exp) begin
                errors++;
                $display("FAIL b2b_bit cycle=%0d actual=%b required=%b", n, serial_tx, exp);
            end
            if (tx_ready !== (n == 100 || n == 200)) begin
                errors++;
                $display("FAIL b2b_ready cycle=%0d actual=%b required=%b", n, tx_ready, (n == 100 || n == 200));
            end
            if (n < 100)       tx_data  = 8'($urandom);
            else if (n == 100) tx_data  = b1;
            else if (n == 101) tx_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_loopback(input logic [7:0] b);
        int base, ebase, a;
        loop_en = 1'b1;
        base  = rxv_cnt;
        ebase = err_cnt;
        tx_accept(b);
        a = cyc;
        repeat (109) @(negedge clk);
        checks += 5;
        if (rxv_cnt - base != 1) begin errors++; $display("FAIL loop_pulses byte=%h actual=%0d required=1", b, rxv_cnt - base); end
        if (rxv_data !== b) begin errors++; $display("FAIL loop_data actual=%h required=%h", rxv_data, b); end
        if (rx_data !== b) begin errors++; $display("FAIL loop_rx_data_hold actual=%h required=%h", rx_data, b); end
        if (err_cnt - ebase != 0) begin errors++; $display("FAIL loop_frame_err actual=%0d required=0", err_cnt - ebase); end
        if (rxv_cyc != a + 9 * CPB + CPB / 2 + 2) begin
            errors++;
            $display("FAIL loop_latency actual=%0d required=%0d", rxv_cyc - a, 9 * CPB + CPB / 2 + 2);
        end
    endtask

    task automatic test_rx_glitch();
        int base, ebase;
        loop_en = 1'b0;
        rx_line = 1'b1;
        repeat (5) @(negedge clk);
        base  = rxv_cnt;
        ebase = err_cnt;
        rx_line = 1'b0;
        repeat (3) @(negedge clk);
        rx_line = 1'b1;
        repeat (40) @(negedge clk);
        checks += 2;
        if (rxv_cnt - base != 0) begin errors++; $display("FAIL glitch_valid actual=%0d required=0", rxv_cnt - base); end
        if (err_cnt - ebase != 0) begin errors++; $display("FAIL glitch_frame_err actual=%0d required=0", err_cnt - ebase); end
        drive_rx_frame(8'h81, 1'b1);
        repeat (10) @(negedge clk);
        checks += 2;
        if (rxv_cnt - base != 1) begin errors++; $display("FAIL glitch_next_valid actual=%0d required=1", rxv_cnt - base); end
        if (rxv_data !== 8'h81) begin errors++; $display("FAIL glitch_next_data actual=%h required=81", rxv_data); end
    endtask

    task automatic test_frame_err();
        int         base, ebase;
        logic [7:0] prev;
        loop_en = 1'b0;
        rx_line = 1'b1;
        prev = 8'($urandom);
        drive_rx_frame(prev, 1'b1);
        repeat (10) @(negedge clk);
        checks++;
        if (rx_data !== prev) begin errors++; $display("FAIL ferr_prior_data actual=%h required=%h", rx_data, prev); end
        base  = rxv_cnt;
        ebase = err_cnt;
        drive_rx_frame(8'h55, 1'b0);
        repeat (30) @(negedge clk);
        checks += 3;
        if (err_cnt - ebase != 1) begin errors++; $display("FAIL ferr_pulse actual=%0d required=1", err_cnt - ebase); end
        if (rxv_cnt - base != 0) begin errors++; $display("FAIL ferr_valid actual=%0d required=0", rxv_cnt - base); end
        if (rx_data !== prev) begin errors++; $display("FAIL ferr_data_kept actual=%h required=%h", rx_data, prev); end
        rx_line = 1'b1;
        repeat (120) @(negedge clk);
        checks += 2;
        if (rxv_cnt - base != 0) begin errors++; $display("FAIL ferr_break_valid actual=%0d required=0", rxv_cnt - base); end
        if (err_cnt - ebase != 1) begin errors++; $display("FAIL ferr_break_err actual=%0d required=1", err_cnt - ebase); end
        drive_rx_frame(8'h81, 1'b1);
        rx_line = 1'b1;
        repeat (10) @(negedge clk);
        checks += 2;
        if (rxv_cnt - base != 1) begin errors++; $display("FAIL ferr_recover_valid actual=%0d required=1", rxv_cnt - base); end
        if (rxv_data !== 8'h81) begin errors++; $display("FAIL ferr_recover_data actual=%h required=81", rxv_data); end
    endtask

    task automatic test_reset_mid_frame();
        int base, ebase;
        loop_en = 1'b1;
        base  = rxv_cnt;
        ebase = err_cnt;
        tx_accept(8'($urandom) & 8'hFE);
        repeat (39) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks += 3;
        if (serial_tx !== 1'b1) begin errors++; $display("FAIL rst_mid_serial_tx actual=%b required=1", serial_tx); end
        if (tx_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_tx_ready actual=%b required=0", tx_ready); end
        if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_rx_data actual=%h required=00", rx_data); end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_release_tx_ready actual=%b required=1", tx_ready); end
        repeat (120) @(negedge clk);
        checks += 3;
        if (serial_tx !== 1'b1) begin errors++; $display("FAIL rst_idle_serial_tx actual=%b required=1", serial_tx); end
        if (rxv_cnt - base != 0) begin errors++; $display("FAIL rst_partial_valid actual=%0d required=0", rxv_cnt - base); end
        if (err_cnt - ebase != 0) begin errors++; $display("FAIL rst_partial_err actual=%0d required=0", err_cnt - ebase); end
    endtask

    task automatic test_variant(input logic [6:0] b);
        int   base, ebase, a, w;
        logic exp;
        base  = rxv7_cnt;
        ebase = err7_cnt;
        w = 0;
        while (!tx_ready7 && w < 400) begin @(negedge clk); w++; end
        tx_data7  = b;
        tx_valid7 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid7 = 1'b0;
        a = cyc;
        for (int n = 1; n <= 100; n++) begin
            if (n > 1) @(negedge clk);
            exp = model_bit({2'b00, b}, 7, n);
            checks += 2;
            if (serial_tx7 !== exp) begin
                errors++;
                $display("FAIL var_bit byte=%h cycle=%0d actual=%b required=%b", b, n, serial_tx7, exp);
            end
            if (tx_ready7 !== (n == 100)) begin
                errors++;
                $display("FAIL var_ready cycle=%0d actual=%b required=%b", n, tx_ready7, (n == 100));
            end
        end
        repeat (20) @(negedge clk);
        checks += 4;
        if (rxv7_cnt - base != 1) begin errors++; $display("FAIL var_pulses actual=%0d required=1", rxv7_cnt - base); end
        if (rxv7_data !== b) begin errors++; $display("FAIL var_data actual=%h required=%h", rxv7_data, b); end
        if (err7_cnt - ebase != 0) begin errors++; $display("FAIL var_frame_err actual=%0d required=0", err7_cnt - ebase); end
        if (rxv7_cyc != a + 8 * CPB + CPB / 2 + 2) begin
            errors++;
            $display("FAIL var_latency actual=%0d required=%0d", rxv7_cyc - a, 8 * CPB + CPB / 2 + 2);
        end
    endtask

    initial begin
        test_reset();
        test_single_tx(8'hA5);
        for (int i = 0; i < 3; i++) test_single_tx(8'($urandom));
        test_back_to_back(8'h00, 8'hFF);
        test_back_to_back(8'($urandom), 8'($urandom));
        test_loopback(8'h3C);
        for (int i = 0; i < 4; i++) test_loopback(8'($urandom));
        test_rx_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_variant(7'h5A);
        test_variant(7'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_core.md
# uart_core

Parametrised full-duplex UART for the on-chip serial link. It has a transmitter with a valid/ready byte interface, a receiver with mid-bit sampling and framing-error detection, and a configurable baud divisor, data width and stop-bit count. It sits between the serial pins and the system bus. It generalises the fixed-rate shift-out transmitter into a complete, framed TX/RX pair.

## Interface
Parameters:
- CLOCK_HZ, default 1_000_000: system clock frequency.
- BAUD_HZ, default 9_600: line rate. CLKS_PER_BIT = CLOCK_HZ / BAUD_HZ, integer division.
- DATA_BITS, default 8: payload bits per frame. Legal range is 5–9.
- STOP_BITS, default 1: stop bits per frame. Legal values are 1 and 2.

Ports:
- clock  in  1  system clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  DATA_BITS  byte to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmitter can accept a byte.
- serial_tx  out  1  serial line out; idles high.
- serial_rx  in  1  serial line in; asynchronous.
- rx_data  out  DATA_BITS  last correctly framed received byte.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- rx_frame_err  out  1  one-cycle pulse when a stop bit is sampled low.

## Operation
- Frame format: start bit (0), then DATA_BITS data bits LSB first, then STOP_BITS stop bits (1). No parity.
- Elaboration rules: fatal error if CLKS_PER_BIT < 4, STOP_BITS is not 1 or 2, or DATA_BITS is outside 5–9.

TX FSM (IDLE → START → DATA → STOP → IDLE):
- A transfer is accepted on a cycle where tx_valid && tx_ready.
- On acceptance, tx_data is latched into the shift register.
- Every bit lasts exactly CLKS_PER_BIT cycles.
- tx_ready is decoded from state. It is high in IDLE and in the final cycle of the last stop bit, so back-to-back frames have no idle gap.
- tx_data is ignored while tx_ready is low.

RX FSM (IDLE → START → DATA → STOP → IDLE, plus BREAK):
- serial_rx passes through a 2-flop synchroniser.
- IDLE: a synchronised low starts the bit timer.
- START: recheck the line at CLKS_PER_BIT/2. If it is high, treat it as a glitch and return to IDLE with no output.
- DATA: sample each data bit every CLKS_PER_BIT cycles from the start-bit midpoint, shifting LSB first.
- STOP: sample only the first stop bit.
  - High: rx_data is updated, rx_valid pulses, and the FSM returns to IDLE at the sample point.
  - Low: rx_frame_err pulses, rx_data is unchanged, and the FSM enters BREAK.
- BREAK: wait for the synchronised line to be high, then go to IDLE.
- There is no RX buffering or backpressure. The consumer must capture rx_data on rx_valid.

TX and RX are fully independent. Simultaneous activity is required to work.

## Timing
While reset is asserted:
- serial_tx = 1, tx_ready = 0, rx_valid = 0, rx_frame_err = 0, rx_data = 0.
- Both FSMs are forced to IDLE and both bit timers to 0.

After reset:
- tx_ready = 1 from the first cycle after reset deasserts.
- Reset mid-frame aborts the frame. serial_tx is 1 on the cycle after reset is sampled, and any partial RX frame is discarded with no pulse.

Latencies and widths:
- TX: acceptance at edge k puts the start bit on serial_tx from cycle k+1. A frame occupies (1+DATA_BITS+STOP_BITS)·CLKS_PER_BIT cycles.
- RX: rx_valid occurs 2 cycles of synchroniser latency plus the mid-stop-bit sample point after the start-bit falling edge, i.e. (DATA_BITS+1)·CLKS_PER_BIT + CLKS_PER_BIT/2 + 2 cycles.
- Bit timer width: $clog2(CLKS_PER_BIT). It wraps to 0 at CLKS_PER_BIT−1.
- Bit index width: $clog2(DATA_BITS+1).

## Structure
- Package uart_pkg holds:
  - tx_state_t and rx_state_t enums;
  - the CLKS_PER_BIT computation function;
  - the legality-check constants.
- Sub-module uart_bit_timer is instantiated twice, once in TX and once in RX.
  - Inputs: clear/start.
  - Outputs: a mid-bit strobe and an end-of-bit strobe, with CLKS_PER_BIT as a parameter.
- The TX path, RX path and synchroniser stay inline in uart_core.

## Test plan
All scenarios use CLOCK_HZ=1_000_000 and BAUD_HZ=100_000, giving CLKS_PER_BIT=10, unless noted.

- **Single TX frame:** TX 0xA5 accepted at cycle 0 → serial_tx is 0 for cycles 1–10, then 1,0,1,0,0,1,0,1 (10 cycles each), then 1 for cycles 91–100; tx_ready is high at cycle 100.
- **Back-to-back TX:** tx_valid held with 0x00 then 0xFF → second start bit begins at cycle 101 with no idle cycle; both frames are 200 cycles total.
- **Loopback:** serial_tx tied to serial_rx, TX 0x3C → exactly one rx_valid pulse, rx_data=0x3C, rx_frame_err never asserted.
- **RX glitch:** serial_rx low for 3 cycles then high → no rx_valid, no rx_frame_err, and a following 0x81 frame is received correctly.
- **Framing error:** 0x55 frame with the stop bit low and the line then held low for 30 cycles → one rx_frame_err pulse and rx_data keeps its previous value. No new frame starts until the line goes high; then 0x81 is received with rx_valid.
- **Reset and variant config:** reset at cycle 40 of a TX frame → serial_tx=1 next cycle and tx_ready=1 the cycle after release. Repeat the loopback with DATA_BITS=7 and STOP_BITS=2: 0x5A gives a 100-cycle frame with rx_data=0x5A.
